// File: rtl/mc_control_unit.sv
// mc_control_unit: multi-cycle ARM-subset control FSM with registered control outputs and CPSR.
// Ports: clk/reset (sync, active-high); Cond/Op/func from the instruction register; ALU_Flag live {N,Z,C,V};
// outputs are datapath write enables, mux selects, ALU_Control, registered CPSR and the current State.
module mc_control_unit #(
    parameter logic [3:0] CPSR_INIT = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] func,
    input  logic [3:0] ALU_Flag,
    output logic       PC_Write,
    output logic       IR_Write,
    output logic       Reg_Write,
    output logic       Mem_Write,
    output logic       Adr_Src,
    output logic       ALU_SrcA,
    output logic [1:0] ALU_SrcB,
    output logic [1:0] Result_Src,
    output logic [2:0] ALU_Control,
    output logic [3:0] CPSR,
    output logic [3:0] State
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8
    } state_t;

    state_t     r_state;
    state_t     w_next;
    state_t     w_go;
    logic       w_cond_ok;
    logic       w_supp;
    logic       w_cmp;
    logic       w_flag_ld;
    logic [2:0] w_alu;
    logic [3:0] w_cmd;

    assign State = r_state;
    assign w_cmd = func[4:1];

    // CPSR is {N,Z,C,V}
    always_comb begin
        w_cond_ok = 1'b0;
        case (Cond)
            4'b0000: w_cond_ok = CPSR[2];
            4'b0001: w_cond_ok = !CPSR[2];
            4'b0010: w_cond_ok = CPSR[1];
            4'b0011: w_cond_ok = !CPSR[1];
            4'b0100: w_cond_ok = CPSR[3];
            4'b0101: w_cond_ok = !CPSR[3];
            4'b1010: w_cond_ok = CPSR[3] == CPSR[0];
            4'b1011: w_cond_ok = CPSR[3] != CPSR[0];
            4'b1110: w_cond_ok = 1'b1;
            default: w_cond_ok = 1'b0;
        endcase
    end

    // w_supp covers commands that write back; CMP is handled separately
    always_comb begin
        w_supp = w_cmd == 4'b0100 || w_cmd == 4'b0010 || w_cmd == 4'b0000 || w_cmd == 4'b1100 || w_cmd == 4'b1101;
        w_cmp  = w_cmd == 4'b1010;
        w_alu  = (w_cmd == 4'b0010 || w_cmp) ? 3'b001 :
                 w_cmd == 4'b0000 ? 3'b010 :
                 w_cmd == 4'b1100 ? 3'b011 :
                 w_cmd == 4'b1101 ? 3'b100 : 3'b000;
        w_flag_ld = r_state == EXEC && ((func[0] && w_supp) || w_cmp);
    end

    always_comb begin
        w_next = FETCH;
        case (r_state)
            FETCH:   w_next = DECODE;
            DECODE:  w_next = (!w_cond_ok || Op == 2'b11) ? FETCH :
                              Op == 2'b01 ? MEMADR :
                              Op == 2'b00 ? EXEC : BRANCH;
            MEMADR:  w_next = func[0] ? MEMRD : MEMWR;
            MEMRD:   w_next = MEMWB;
            EXEC:    w_next = w_supp ? ALUWB : FETCH;
            default: w_next = FETCH;
        endcase
        w_go = reset ? FETCH : w_next;
    end

    // Outputs are decoded from the state being entered, so they are registered alongside it
    always_ff @(posedge clk) begin
        r_state     <= w_go;
        CPSR        <= reset ? CPSR_INIT : w_flag_ld ? ALU_Flag : CPSR;
        PC_Write    <= w_go == FETCH || w_go == BRANCH;
        IR_Write    <= w_go == FETCH;
        Reg_Write   <= w_go == MEMWB || w_go == ALUWB;
        Mem_Write   <= w_go == MEMWR;
        Adr_Src     <= w_go == MEMRD || w_go == MEMWR;
        ALU_SrcA    <= w_go == FETCH || w_go == BRANCH;
        ALU_SrcB    <= w_go == FETCH ? 2'b10 :
                       (w_go == MEMADR || w_go == BRANCH) ? 2'b01 :
                       w_go == EXEC ? {1'b0, func[5]} : 2'b00;
        Result_Src  <= (w_go == FETCH || w_go == BRANCH) ? 2'b10 : w_go == MEMWB ? 2'b01 : 2'b00;
        ALU_Control <= w_go == EXEC ? w_alu : 3'b000;
    end
endmodule

// File: tb/tb_mc_control_unit.sv
// tb_mc_control_unit: directed self-checking bench for mc_control_unit.
module tb_mc_control_unit;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] func;
    logic [3:0] ALU_Flag;
    logic       PC_Write, IR_Write, Reg_Write, Mem_Write, Adr_Src, ALU_SrcA;
    logic [1:0] ALU_SrcB, Result_Src;
    logic [2:0] ALU_Control;
    logic [3:0] CPSR, State;
    logic [12:0] cw;
    int cnt = 0;
    int errs = 0;

    // {PC_Write,IR_Write,Reg_Write,Mem_Write,Adr_Src,ALU_SrcA,ALU_SrcB,Result_Src,ALU_Control}
    localparam logic [12:0] W_F  = 13'b1100_0_1_10_10_000;
    localparam logic [12:0] W_D  = 13'b0000_0_0_00_00_000;
    localparam logic [12:0] W_EA = 13'b0000_0_0_01_00_000;
    localparam logic [12:0] W_AW = 13'b0010_0_0_00_00_000;
    localparam logic [12:0] W_MA = 13'b0000_0_0_01_00_000;
    localparam logic [12:0] W_MR = 13'b0000_1_0_00_00_000;
    localparam logic [12:0] W_MB = 13'b0010_0_0_00_01_000;
    localparam logic [12:0] W_MW = 13'b0001_1_0_00_00_000;
    localparam logic [12:0] W_BR = 13'b1000_0_1_01_10_000;
    localparam logic [12:0] W_EC = 13'b0000_0_0_00_00_001;
    localparam logic [12:0] W_EO = 13'b0000_0_0_00_00_011;
    localparam logic [12:0] W_EM = 13'b0000_0_0_01_00_100;

    always #5 clk = ~clk;

    assign cw = {PC_Write, IR_Write, Reg_Write, Mem_Write, Adr_Src, ALU_SrcA, ALU_SrcB, Result_Src, ALU_Control};

    mc_control_unit dut (
        .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .func(func), .ALU_Flag(ALU_Flag),
        .PC_Write(PC_Write), .IR_Write(IR_Write), .Reg_Write(Reg_Write), .Mem_Write(Mem_Write),
        .Adr_Src(Adr_Src), .ALU_SrcA(ALU_SrcA), .ALU_SrcB(ALU_SrcB), .Result_Src(Result_Src),
        .ALU_Control(ALU_Control), .CPSR(CPSR), .State(State)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        cnt++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic [3:0] st, input logic [12:0] w);
        chk({tag, "_state"}, 16'(State), 16'(st));
        chk({tag, "_ctrl"}, 16'(cw), 16'(w));
        @(negedge clk);
    endtask

    task automatic set_in(input logic [1:0] op, input logic [5:0] fn, input logic [3:0] cd, input logic [3:0] fl);
        Op = op;
        func = fn;
        Cond = cd;
        ALU_Flag = fl;
    endtask

    initial begin
        reset = 1'b1;
        set_in(2'b00, 6'b000000, 4'b1110, 4'b0000);
        @(negedge clk);
        @(negedge clk);
        chk("rst_cpsr", 16'(CPSR), 16'h0);
        reset = 1'b0;
        set_in(2'b00, 6'b101001, 4'b1110, 4'b0100);
        cyc("add_f", 4'd0, W_F);
        cyc("add_d", 4'd1, W_D);
        chk("add_cpsr_pre", 16'(CPSR), 16'h0);
        cyc("add_e", 4'd6, W_EA);
        chk("add_cpsr", 16'(CPSR), 16'h4);
        cyc("add_w", 4'd7, W_AW);
        set_in(2'b01, 6'b000001, 4'b1110, 4'b0000);
        cyc("ld_f", 4'd0, W_F);
        cyc("ld_d", 4'd1, W_D);
        cyc("ld_a", 4'd2, W_MA);
        cyc("ld_r", 4'd3, W_MR);
        cyc("ld_b", 4'd4, W_MB);
        set_in(2'b01, 6'b000000, 4'b1110, 4'b1111);
        cyc("st_f", 4'd0, W_F);
        cyc("st_d", 4'd1, W_D);
        cyc("st_a", 4'd2, W_MA);
        cyc("st_w", 4'd5, W_MW);
        chk("st_cpsr", 16'(CPSR), 16'h4);
        set_in(2'b10, 6'b000000, 4'b0000, 4'b0000);
        cyc("beq_f", 4'd0, W_F);
        cyc("beq_d", 4'd1, W_D);
        cyc("beq_b", 4'd8, W_BR);
        set_in(2'b00, 6'b010100, 4'b1110, 4'b1001);
        cyc("cmp_f", 4'd0, W_F);
        cyc("cmp_d", 4'd1, W_D);
        cyc("cmp_e", 4'd6, W_EC);
        chk("cmp_cpsr", 16'(CPSR), 16'h9);
        set_in(2'b10, 6'b000000, 4'b0000, 4'b0000);
        cyc("beqx_f", 4'd0, W_F);
        cyc("beqx_d", 4'd1, W_D);
        set_in(2'b10, 6'b000000, 4'b0001, 4'b0000);
        cyc("bne_f", 4'd0, W_F);
        cyc("bne_d", 4'd1, W_D);
        cyc("bne_b", 4'd8, W_BR);
        set_in(2'b10, 6'b000000, 4'b1010, 4'b0000);
        cyc("bge_f", 4'd0, W_F);
        cyc("bge_d", 4'd1, W_D);
        cyc("bge_b", 4'd8, W_BR);
        set_in(2'b10, 6'b000000, 4'b1011, 4'b0000);
        cyc("blt_f", 4'd0, W_F);
        cyc("blt_d", 4'd1, W_D);
        set_in(2'b10, 6'b000000, 4'b0110, 4'b0000);
        cyc("bnv_f", 4'd0, W_F);
        cyc("bnv_d", 4'd1, W_D);
        set_in(2'b11, 6'b000000, 4'b1110, 4'b0000);
        cyc("ill_f", 4'd0, W_F);
        cyc("ill_d", 4'd1, W_D);
        set_in(2'b00, 6'b011000, 4'b1110, 4'b0110);
        cyc("orr_f", 4'd0, W_F);
        cyc("orr_d", 4'd1, W_D);
        cyc("orr_e", 4'd6, W_EO);
        cyc("orr_w", 4'd7, W_AW);
        chk("orr_cpsr", 16'(CPSR), 16'h9);
        set_in(2'b00, 6'b000011, 4'b1110, 4'b0110);
        cyc("nop_f", 4'd0, W_F);
        cyc("nop_d", 4'd1, W_D);
        cyc("nop_e", 4'd6, W_D);
        chk("nop_cpsr", 16'(CPSR), 16'h9);
        set_in(2'b00, 6'b111011, 4'b1110, 4'b0110);
        cyc("mov_f", 4'd0, W_F);
        cyc("mov_d", 4'd1, W_D);
        cyc("mov_e", 4'd6, W_EM);
        chk("mov_cpsr", 16'(CPSR), 16'h6);
        cyc("mov_w", 4'd7, W_AW);
        set_in(2'b01, 6'b000001, 4'b1110, 4'b0000);
        cyc("rld_f", 4'd0, W_F);
        cyc("rld_d", 4'd1, W_D);
        cyc("rld_a", 4'd2, W_MA);
        reset = 1'b1;
        cyc("rld_r", 4'd3, W_MR);
        chk("rld_cpsr", 16'(CPSR), 16'h0);
        reset = 1'b0;
        set_in(2'b11, 6'b000000, 4'b1110, 4'b0000);
        cyc("rld_post_f", 4'd0, W_F);
        cyc("rld_post_d", 4'd1, W_D);
        cyc("end_f", 4'd0, W_F);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt, errs);
        $finish;
    end
endmodule
